fmul_arbiter: RTL and testbench
===============================

FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N presents an operation.
REQ-004 SHALL have ports req0_ready / req1_ready, output, 1 bit each: operation of requester N is accepted this cycle.
REQ-005 SHALL have ports req0_x1, req0_x2, req1_x1, req1_x2, input, 32 bits each: IEEE-754 single-precision operands.
REQ-006 SHALL have ports req0_tag / req1_tag, input, 4 bits each: opaque tag, echoed with the result.
REQ-007 SHALL have port out_valid, output, 1 bit: the result at the head of the result FIFO is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL have port out_y, output, 32 bits: product.
REQ-010 SHALL have port out_id, output, 1 bit: index of the requester that issued the result.
REQ-011 SHALL have port out_tag, output, 4 bits: tag of the issuing operation.
REQ-012 SHALL have port busy, output, 1 bit: high while an operation is in flight or the FIFO is non-empty.

Function
REQ-013 SHALL contain one shared two-stage multiplier: combinational mantissa product and exponent sum, one internal register with no enable, then combinational normalize/pack; it produces one product per cycle.
REQ-014 SHALL use the same product semantics as the team's fmul: zero if either exponent field is 0; result flushed to zero on underflow; inf on exponent overflow; no rounding (truncate).
REQ-015 SHALL issue at most one operation per cycle; issue = reqN_valid && grantN && credit_ok; reqN_ready equals the issue condition for N and may depend combinationally on reqN_valid.
REQ-016 SHALL define credit_ok = (fifo_count + inflight - pop) < 2, where inflight = an operation was issued the previous cycle and pop = out_valid && out_ready.
REQ-017 SHALL have a fixed latency: an operation issued in cycle t writes the FIFO at the end of cycle t+1; with an empty FIFO, out_valid rises in cycle t+2.
REQ-018 SHALL carry id and tag in a 1-stage side pipeline aligned with the internal multiplier register.
REQ-019 SHALL use a 2-entry result FIFO: in-order, simultaneous push and pop allowed at count 1 and count 2, no overflow possible by construction (credit rule); pop at count 0 is ignored.
REQ-020 SHALL sustain one issue per cycle with out_ready held high (steady state: inflight=1, fifo_count=1, pop=1).
REQ-021 SHALL stop issuing when out_ready is low after at most 2 outstanding results; reqN_ready=0 until a pop frees a credit.
REQ-022 SHALL keep out_y/out_id/out_tag stable while out_valid && !out_ready.
REQ-023 SHALL, when only one requester is valid, grant it regardless of arbitration state.

Reset
REQ-024 SHALL, while rst is high, force out_valid=0, busy=0, req0_ready=0, req1_ready=0, fifo_count=0, inflight=0, and the round-robin pointer to favour requester 0; out_y/out_tag/out_id SHALL read 0.
REQ-025 SHALL discard the in-flight operation and all FIFO contents when rst is asserted mid-operation; no result SHALL appear after deassertion.

Configuration
REQ-026 SHALL, with FMUL_ARB_RR_EN defined, arbitrate round-robin: when both requesters are valid, grant the one not granted at the last issue; the pointer updates only on an issue.
REQ-027 SHALL, without FMUL_ARB_RR_EN, use fixed priority: requester 0 always wins when both are valid (requester 1 may starve).

Verification
REQ-028 SHALL cover: req0 issues 0x40000000 x 0x40400000, tag 3, at t, out_ready=1 -> out_valid at t+2, out_y=0x40C00000, out_id=0, out_tag=3, busy low at t+3.
REQ-029 SHALL cover: both requesters valid for 4 cycles, RR build -> grants 0,1,0,1 and results in that order; without the macro -> grants 0,0,0,0.
REQ-030 SHALL cover: out_ready=0, req0 valid continuously -> exactly 2 issues, then req0_ready=0; raise out_ready -> 1 pop per cycle, issue resumes the same cycle as the first pop.
REQ-031 SHALL cover: 0x3FC00000 x 0x3FC00000 -> 0x40100000; 0x00000000 x 0x7F000000 -> 0x00000000; 0x7F000000 x 0x7F000000 -> 0x7F800000.
REQ-032 SHALL cover: rst pulsed the cycle after an issue -> no out_valid ever for that operation; the next issue after reset completes normally.

Source files
------------

// File: rtl/fmul_arbiter_if.sv
// Handshake bundle between two fmul requesters, the shared multiplier and the result consumer.
interface fmul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_x1;
  logic [31:0] req0_x2;
  logic [3:0]  req0_tag;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_x1;
  logic [31:0] req1_x2;
  logic [3:0]  req1_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_id;
  logic [3:0]  out_tag;
  logic        busy;

  modport slave (
    input  req0_valid, req0_x1, req0_x2, req0_tag,
    input  req1_valid, req1_x1, req1_x2, req1_tag,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_y, out_id, out_tag, busy
  );

  modport master (
    output req0_valid, req0_x1, req0_x2, req0_tag,
    output req1_valid, req1_x1, req1_x2, req1_tag,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_y, out_id, out_tag, busy
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Two requesters share one 2-stage truncating fmul feeding a 2-entry credit-managed result FIFO.
// Define FMUL_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module fmul_arbiter (
  input  logic          clk,
  input  logic          rst,
  fmul_arbiter_if.slave bus
);
  logic        grant0, grant1, issue0, issue1, credit_ok, pop, push;
  logic [2:0]  occ;
  logic [31:0] op_x1, op_x2, y;
  logic [47:0] m_prod;
  logic        unused_prod_lsbs;

  logic [24:0] prod_d, prod_q;
  logic [8:0]  exp_d, exp_q;
  logic        sign_d, sign_q, zero_d, zero_q;
  logic        id_d, id_q, inflight_d, inflight_q;
  logic [3:0]  tag_d, tag_q;

  logic [36:0] ent0_d, ent0_q, ent1_d, ent1_q, new_ent;
  logic [1:0]  count_d, count_q;

  logic        norm;
  logic [22:0] frac;
  logic [10:0] e_b, e_res;

`ifdef FMUL_ARB_RR_EN
  logic rr_d, rr_q;
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_q);
  always_comb begin
    rr_d = rr_q;
    if (issue0)      rr_d = 1'b1;
    else if (issue1) rr_d = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
`else
  assign grant0 = bus.req0_valid;
  assign grant1 = bus.req1_valid && !bus.req0_valid;
`endif

  assign pop       = (count_q != 2'd0) && bus.out_ready;
  assign push      = inflight_q;
  assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit_ok = occ < 3'd2;
  assign issue0    = !rst && grant0 && credit_ok;
  assign issue1    = !rst && grant1 && credit_ok;

  // Stage 1: operand mux, mantissa product, raw exponent sum (bias removed in stage 2)
  always_comb begin
    op_x1      = issue1 ? bus.req1_x1 : bus.req0_x1;
    op_x2      = issue1 ? bus.req1_x2 : bus.req0_x2;
    m_prod     = {1'b1, op_x1[22:0]} * {1'b1, op_x2[22:0]};
    prod_d     = m_prod[47:23];
    exp_d      = {1'b0, op_x1[30:23]} + {1'b0, op_x2[30:23]};
    sign_d     = op_x1[31] ^ op_x2[31];
    zero_d     = (op_x1[30:23] == 8'd0) || (op_x2[30:23] == 8'd0);
    id_d       = issue1;
    tag_d      = issue1 ? bus.req1_tag : bus.req0_tag;
    inflight_d = issue0 || issue1;
  end
  assign unused_prod_lsbs = ^m_prod[22:0];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      id_q       <= 1'b0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      id_q       <= id_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end

  // Stage 2: normalize and pack; biased exponent e_b <= 127 underflows, >= 382 overflows
  always_comb begin
    norm  = prod_q[24];
    frac  = norm ? prod_q[23:1] : prod_q[22:0];
    e_b   = {2'b0, exp_q} + {10'b0, norm};
    e_res = e_b - 11'd127;
    if (zero_q || e_b <= 11'd127) y = 32'h0000_0000;
    else if (e_b >= 11'd382)      y = {sign_q, 8'hFF, 23'd0};
    else                          y = {sign_q, e_res[7:0], frac};
    new_ent = {id_q, tag_q, y};
  end

  // Shift FIFO: entry 0 is always the head
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = new_ent;
        else                 ent1_d = new_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) ent0_d = new_ent;
        else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end

  assign bus.req0_ready = issue0;
  assign bus.req1_ready = issue1;
  assign bus.out_valid  = count_q != 2'd0;
  assign bus.out_id     = ent0_q[36];
  assign bus.out_tag    = ent0_q[35:32];
  assign bus.out_y      = ent0_q[31:0];
  assign bus.busy       = inflight_q || (count_q != 2'd0);
endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed self-checking bench for fmul_arbiter; expected grant order follows FMUL_ARB_RR_EN.
module tb_fmul_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fmul_arbiter_if bus();
  fmul_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    cyc();
    bus.req0_valid = 1'b1; bus.req0_x1 = a; bus.req0_x2 = b; bus.req0_tag = 4'h7;
    #1 chk({name, "_ready"}, {31'd0, bus.req0_ready}, 32'd1);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, "_y"}, bus.out_y, exp);
    cyc();
  endtask

  logic [0:3] exp_id;
  logic [3:0] tag_d_exp [0:7];
  logic       rdy_d_exp [0:5];

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_x1 = '0; bus.req0_x2 = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_x1 = '0; bus.req1_x2 = '0; bus.req1_tag = '0;
    bus.out_ready  = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_out_y",     bus.out_y, 32'd0);
    chk("rst_out_tag",   {28'd0, bus.out_tag}, 32'd0);
    cyc();
    rst = 1'b0;

    // Basic latency: 2.0 x 3.0, tag 3
    cyc();
    bus.req0_valid = 1'b1; bus.req0_x1 = 32'h4000_0000; bus.req0_x2 = 32'h4040_0000;
    bus.req0_tag = 4'h3;
    #1 chk("lat_ready_t", {31'd0, bus.req0_ready}, 32'd1);
    cyc();
    bus.req0_valid = 1'b0;
    chk("lat_valid_t1", {31'd0, bus.out_valid}, 32'd0);
    chk("lat_busy_t1",  {31'd0, bus.busy}, 32'd1);
    cyc();
    chk("lat_valid_t2", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_y",        bus.out_y, 32'h40C0_0000);
    chk("lat_id",       {31'd0, bus.out_id}, 32'd0);
    chk("lat_tag",      {28'd0, bus.out_tag}, 32'd3);
    cyc();
    chk("lat_valid_t3", {31'd0, bus.out_valid}, 32'd0);
    chk("lat_busy_t3",  {31'd0, bus.busy}, 32'd0);

    run_op("v_1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    run_op("v_zero",  32'h0000_0000, 32'h7F00_0000, 32'h0000_0000);
    run_op("v_inf",   32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    run_op("v_neg",   32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    run_op("v_uflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);

    // Arbitration with both requesters valid for 4 cycles
`ifdef FMUL_ARB_RR_EN
    exp_id = 4'b0101;
`else
    exp_id = 4'b0000;
`endif
    do_reset();
    bus.req0_x1 = 32'h4000_0000; bus.req0_x2 = 32'h4040_0000; bus.req0_tag = 4'h5;
    bus.req1_x1 = 32'h3FC0_0000; bus.req1_x2 = 32'h3FC0_0000; bus.req1_tag = 4'hA;
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.req0_valid = (k < 4);
      bus.req1_valid = (k < 4);
      #1;
      if (k < 4) begin
        chk($sformatf("arb_rdy0_%0d", k), {31'd0, bus.req0_ready}, {31'd0, !exp_id[k]});
        chk($sformatf("arb_rdy1_%0d", k), {31'd0, bus.req1_ready}, {31'd0, exp_id[k]});
      end
      if (k >= 2) begin
        chk($sformatf("arb_ov_%0d", k),  {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("arb_id_%0d", k),  {31'd0, bus.out_id}, {31'd0, exp_id[k-2]});
        chk($sformatf("arb_tag_%0d", k), {28'd0, bus.out_tag}, exp_id[k-2] ? 32'hA : 32'h5);
        chk($sformatf("arb_y_%0d", k),   bus.out_y,
            exp_id[k-2] ? 32'h4010_0000 : 32'h40C0_0000);
      end
    end
    cyc();
    chk("arb_drain", {31'd0, bus.out_valid}, 32'd0);

    // Back-pressure: two credits, then stall until the first pop
    rdy_d_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tag_d_exp = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h5, 4'h6};
    bus.req0_x1 = 32'h4000_0000; bus.req0_x2 = 32'h4040_0000;
    for (int k = 0; k < 9; k++) begin
      cyc();
      bus.req0_valid = (k < 6);
      bus.req0_tag   = 4'(k + 1);
      bus.out_ready  = (k >= 4);
      #1;
      if (k < 6) chk($sformatf("bp_rdy_%0d", k), {31'd0, bus.req0_ready}, {31'd0, rdy_d_exp[k]});
      if (k >= 2 && k < 8) begin
        chk($sformatf("bp_ov_%0d", k),  {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("bp_tag_%0d", k), {28'd0, bus.out_tag}, {28'd0, tag_d_exp[k]});
        chk($sformatf("bp_y_%0d", k),   bus.out_y, 32'h40C0_0000);
      end
      if (k == 8) chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.out_ready = 1'b1;

    // Reset the cycle after an issue: the result must never appear
    cyc();
    bus.req0_valid = 1'b1; bus.req0_tag = 4'h9;
    #1 chk("mr_issue", {31'd0, bus.req0_ready}, 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    chk("mr_rdy_in_rst",  {31'd0, bus.req0_ready}, 32'd0);
    chk("mr_busy_in_rst", {31'd0, bus.busy}, 32'd0);
    chk("mr_ov_in_rst",   {31'd0, bus.out_valid}, 32'd0);
    cyc();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("mr_no_out_%0d", k), {31'd0, bus.out_valid}, 32'd0);
      cyc();
    end
    run_op("mr_after", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
